// File: rtl/tage_pkg.sv
// Shared types and width helpers for the TAGE update path.
package tage_pkg;

  localparam int unsigned TAGE_TABLE_NUM = 4;
  localparam int unsigned TAGE_PC_WIDTH  = 32;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packed width of one queued update: {pc, taken, mispredict, provider_hit, provider_id}.
  function automatic int unsigned req_width(input int unsigned pc_w, input int unsigned n);
    return pc_w + 3 + id_width(n);
  endfunction

  localparam int unsigned TAGE_ID_WIDTH = id_width(TAGE_TABLE_NUM);

  typedef struct packed {
    logic [TAGE_PC_WIDTH-1:0] pc;
    logic                     taken;
    logic                     mispredict;
    logic                     provider_hit;
    logic [TAGE_ID_WIDTH-1:0] provider_id;
  } tage_update_req_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority first-one picker: searches req_i upward from start_i with wrap-around.
module rr_picker
  import tage_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = id_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    gnt_o,
  output logic            valid_o
);

  always_comb begin
    logic [IdxW-1:0] idx;
    idx     = '0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IdxW'((32'(start_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tage_update_scheduler.sv
// Buffers up to two commit-stage updates per cycle and issues one per cycle to the tagged tables,
// selecting the provider table plus a rotating allocation target on mispredicts.
module tage_update_scheduler
  import tage_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = TAGE_PC_WIDTH,
  parameter int unsigned TABLE_NUM      = TAGE_TABLE_NUM,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FAIL_CNT_WIDTH = 8,
  localparam int unsigned IdW = id_width(TABLE_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [1:0]                in_valid_i,
  input  logic [2*PC_WIDTH-1:0]     in_pc_i,
  input  logic [1:0]                in_taken_i,
  input  logic [1:0]                in_mispredict_i,
  input  logic [1:0]                in_provider_hit_i,
  input  logic [2*IdW-1:0]          in_provider_id_i,
  output logic                      in_ready_o,
  output logic [TABLE_NUM-1:0]      update_valid_o,
  output logic [PC_WIDTH:0]         update_instr_info_o,
  output logic [FAIL_CNT_WIDTH-1:0] alloc_fail_cnt_o,
  output logic                      busy_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = req_width(PC_WIDTH, TABLE_NUM);

  typedef enum logic [1:0] {StIdle, StIssue, StFlush} state_e;

  state_e                    state_q, state_d;
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr1_ptr;
  logic [CntW-1:0]           count_q, count_d;
  logic [IdW-1:0]            alloc_ptr_q, alloc_ptr_d;
  logic [FAIL_CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
  logic [TABLE_NUM-1:0]      upd_valid_q, upd_valid_d;
  logic [PC_WIDTH:0]         info_q, info_d;
  logic [EntW-1:0]           mem_q [FIFO_DEPTH];
  logic [EntW-1:0]           mem_d [FIFO_DEPTH];
  logic [EntW-1:0]           lane_ent [2];

  logic                 acc0, acc1, issue;
  logic [PC_WIDTH-1:0]  head_pc;
  logic                 head_taken, head_misp, head_hit;
  logic [IdW-1:0]       head_id;
  logic [TABLE_NUM-1:0] elig, gnt, mask;
  logic                 pick_valid;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign lane_ent[l] = {in_pc_i[l*PC_WIDTH +: PC_WIDTH], in_taken_i[l], in_mispredict_i[l],
                          in_provider_hit_i[l], in_provider_id_i[l*IdW +: IdW]};
  end

  assign {head_pc, head_taken, head_misp, head_hit, head_id} = mem_q[rd_ptr_q];

  // Only tables with longer history than the provider may take a new entry.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < TABLE_NUM; i++) begin
      elig[i] = !head_hit || (i > 32'(head_id));
    end
  end

  rr_picker #(
    .N(TABLE_NUM)
  ) u_alloc_picker (
    .req_i  (elig),
    .start_i(alloc_ptr_q),
    .gnt_o  (gnt),
    .valid_o(pick_valid)
  );

  assign in_ready_o = (CntW'(FIFO_DEPTH) - count_q >= CntW'(2)) && (state_q != StFlush);

  always_comb begin
    acc0        = in_ready_o && in_valid_i[0] && !flush_i;
    acc1        = in_ready_o && in_valid_i[1] && !flush_i;
    issue       = (state_q == StIssue) && (count_q != '0) && !flush_i;
    wr1_ptr     = wr_ptr_q + PtrW'(acc0);
    mem_d       = mem_q;
    alloc_ptr_d = alloc_ptr_q;
    fail_cnt_d  = fail_cnt_q;
    info_d      = info_q;
    upd_valid_d = '0;

    if (acc0) mem_d[wr_ptr_q] = lane_ent[0];
    if (acc1) mem_d[wr1_ptr]  = lane_ent[1];

    mask = '0;
    if (head_hit) mask[head_id] = 1'b1;
    if (head_misp) mask = mask | gnt;

    if (issue) begin
      upd_valid_d = mask;
      if (|mask) info_d = {head_pc, head_taken};
      if (head_misp) begin
        if (pick_valid) begin
          for (int unsigned i = 0; i < TABLE_NUM; i++) begin
            if (gnt[i]) alloc_ptr_d = IdW'((i + 1) % TABLE_NUM);
          end
        end else if (fail_cnt_q != '1) begin
          fail_cnt_d = fail_cnt_q + FAIL_CNT_WIDTH'(1);
        end
      end
    end

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = StFlush;
    end else begin
      wr_ptr_d = wr1_ptr + PtrW'(acc1);
      rd_ptr_d = rd_ptr_q + PtrW'(issue);
      count_d  = count_q + CntW'(acc0) + CntW'(acc1) - CntW'(issue);
      state_d  = (count_d != '0) ? StIssue : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alloc_ptr_q <= '0;
      fail_cnt_q  <= '0;
      upd_valid_q <= '0;
      info_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alloc_ptr_q <= alloc_ptr_d;
      fail_cnt_q  <= fail_cnt_d;
      upd_valid_q <= upd_valid_d;
      info_q      <= info_d;
    end
  end

  // Storage needs no reset: pointers and count gate every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign update_valid_o      = upd_valid_q;
  assign update_instr_info_o = info_q;
  assign alloc_fail_cnt_o    = fail_cnt_q;
  assign busy_o              = (count_q != '0) || (|upd_valid_q);

endmodule

// File: tb/tb_tage_update_scheduler.sv
// Directed and random stimulus for tage_update_scheduler against a queue-based reference model.
module tb_tage_update_scheduler;
  import tage_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic [1:0]  in_valid_i;
  logic [63:0] in_pc_i;
  logic [1:0]  in_taken_i, in_mispredict_i, in_provider_hit_i;
  logic [3:0]  in_provider_id_i;
  logic        in_ready_o;
  logic [3:0]  update_valid_o;
  logic [32:0] update_instr_info_o;
  logic [7:0]  alloc_fail_cnt_o;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

  tage_update_req_t lane [2];
  tage_update_req_t mq [$];
  logic [31:0]      obs_q [$];
  int               m_ptr, m_fail;
  logic [3:0]       m_valid;
  logic [32:0]      m_info;
  bit               m_flushed;
  logic             last_rdy;

  tage_update_scheduler dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush_i            (flush_i),
    .in_valid_i         (in_valid_i),
    .in_pc_i            (in_pc_i),
    .in_taken_i         (in_taken_i),
    .in_mispredict_i    (in_mispredict_i),
    .in_provider_hit_i  (in_provider_hit_i),
    .in_provider_id_i   (in_provider_id_i),
    .in_ready_o         (in_ready_o),
    .update_valid_o     (update_valid_o),
    .update_instr_info_o(update_instr_info_o),
    .alloc_fail_cnt_o   (alloc_fail_cnt_o),
    .busy_o             (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs(input logic [1:0] v, input logic fl);
    in_valid_i        = v;
    flush_i           = fl;
    in_pc_i           = {lane[1].pc, lane[0].pc};
    in_taken_i        = {lane[1].taken, lane[0].taken};
    in_mispredict_i   = {lane[1].mispredict, lane[0].mispredict};
    in_provider_hit_i = {lane[1].provider_hit, lane[0].provider_hit};
    in_provider_id_i  = {lane[1].provider_id, lane[0].provider_id};
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic tk, input logic mp,
                          input logic hit, input logic [1:0] id);
    lane[l].pc           = pc;
    lane[l].taken        = tk;
    lane[l].mispredict   = mp;
    lane[l].provider_hit = hit;
    lane[l].provider_id  = id;
  endtask

  task automatic rand_lane(input int l);
    set_lane(l, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  // Reference: provider bit, plus first eligible table at or after the pointer on a mispredict.
  task automatic model_pop();
    tage_update_req_t r;
    logic [3:0] mask;
    bit found;
    int t;
    r = mq.pop_front();
    mask = '0;
    found = 0;
    if (r.provider_hit) mask = mask | 4'(1 << int'(r.provider_id));
    if (r.mispredict) begin
      for (int k = 0; k < 4; k++) begin
        t = (m_ptr + k) % 4;
        if (!found && (!r.provider_hit || t > int'(r.provider_id))) begin
          mask = mask | 4'(1 << t);
          m_ptr = (t + 1) % 4;
          found = 1;
        end
      end
      if (!found && m_fail < 255) m_fail++;
    end
    m_valid = mask;
    if (mask != 0) m_info = {r.pc, r.taken};
  endtask

  task automatic step(input logic [1:0] v, input logic fl);
    bit exp_rdy;
    apply_inputs(v, fl);
    #1;
    exp_rdy = (DEPTH - mq.size() >= 2) && !m_flushed;
    check("in_ready", 64'(in_ready_o), 64'(exp_rdy));
    last_rdy = in_ready_o;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_valid = '0;
      m_flushed = 1;
    end else begin
      m_flushed = 0;
      if (mq.size() > 0) model_pop();
      else m_valid = '0;
      if (exp_rdy) begin
        if (v[0]) mq.push_back(lane[0]);
        if (v[1]) mq.push_back(lane[1]);
      end
    end
    #1;
    check("update_valid", 64'(update_valid_o), 64'(m_valid));
    check("instr_info", 64'(update_instr_info_o), 64'(m_info));
    check("fail_cnt", 64'(alloc_fail_cnt_o), 64'(m_fail));
    check("busy", 64'(busy_o), 64'((mq.size() > 0) || (m_valid != 0)));
    if (update_valid_o != 0) obs_q.push_back(update_instr_info_o[32:1]);
    apply_inputs(2'b00, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 1'b0);
  endtask

  // Asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ptr = 0;
    m_fail = 0;
    m_valid = '0;
    m_info = '0;
    m_flushed = 0;
    check("rst_update_valid", 64'(update_valid_o), 64'(0));
    check("rst_in_ready", 64'(in_ready_o), 64'(1));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_fail_cnt", 64'(alloc_fail_cnt_o), 64'(0));
    check("rst_info", 64'(update_instr_info_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int guard;
    logic [2:0] rdy_hist;
    rst_n = 1'b0;
    set_lane(0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    set_lane(1, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply_inputs(2'b00, 1'b0);
    #3;
    do_reset();

    // Single update through provider table 2.
    set_lane(0, 32'h1C00_0040, 1'b1, 1'b0, 1'b1, 2'd2);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    check("single_mask", 64'(update_valid_o), 64'(4'b0100));
    check("single_info", 64'(update_instr_info_o), 64'({32'h1C00_0040, 1'b1}));
    step(2'b00, 1'b0);
    check("single_busy_fall", 64'(busy_o), 64'(0));

    // Mispredict allocation rotates through tables above the provider.
    set_lane(0, 32'h2000_0010, 1'b0, 1'b1, 1'b1, 2'd1);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    check("alloc_first", 64'(update_valid_o), 64'(4'b0110));
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    check("alloc_second", 64'(update_valid_o), 64'(4'b1010));

    // Allocation failure and counter saturation.
    do_reset();
    set_lane(0, 32'h3000_0000, 1'b1, 1'b1, 1'b1, 2'd3);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    check("fail_mask", 64'(update_valid_o), 64'(4'b1000));
    check("fail_cnt_one", 64'(alloc_fail_cnt_o), 64'(1));
    repeat (299) step(2'b01, 1'b0);
    idle(3);
    check("fail_cnt_sat", 64'(alloc_fail_cnt_o), 64'(255));

    // Back-pressure with a producer that holds rejected pairs.
    obs_q.delete();
    sent = 0;
    guard = 0;
    rdy_hist = '0;
    while (sent < 3 && guard < 20) begin
      set_lane(0, 32'h4000_0000 + 32'(sent * 16), 1'b0, 1'b0, 1'b1, 2'd0);
      set_lane(1, 32'h4000_0004 + 32'(sent * 16), 1'b1, 1'b0, 1'b1, 2'd1);
      step(2'b11, 1'b0);
      if (guard < 3) rdy_hist[guard] = last_rdy;
      if (last_rdy) sent++;
      guard++;
    end
    check("bp_bound", 64'(sent), 64'(3));
    check("bp_ready_pattern", 64'(rdy_hist), 64'(3'b011));
    idle(8);
    check("bp_count", 64'(obs_q.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      check("bp_order", 64'((i < obs_q.size()) ? obs_q[i] : 32'hDEAD_BEEF),
            64'(32'h4000_0000 + 32'((i / 2) * 16 + (i % 2) * 4)));
    end

    // Flush during an active drain.
    set_lane(0, 32'h5000_0000, 1'b1, 1'b0, 1'b1, 2'd0);
    set_lane(1, 32'h5000_0004, 1'b1, 1'b0, 1'b1, 2'd1);
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    step(2'b00, 1'b1);
    obs_q.delete();
    check("flush_no_update", 64'(update_valid_o), 64'(0));
    step(2'b11, 1'b0);
    check("flush_ready_low", 64'(last_rdy), 64'(0));
    check("flush_idle_busy", 64'(busy_o), 64'(0));
    idle(3);
    check("flush_no_stale", 64'(obs_q.size()), 64'(0));

    // Asynchronous reset mid-drain.
    step(2'b11, 1'b0);
    step(2'b11, 1'b0);
    check("pre_reset_active", 64'(update_valid_o != 0), 64'(1));
    do_reset();
    obs_q.delete();
    idle(4);
    check("post_reset_no_stale", 64'(obs_q.size()), 64'(0));

    // Random traffic with occasional flushes.
    repeat (500) begin
      rand_lane(0);
      rand_lane(1);
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
